// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the core's memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states,
// byte-enabled stores and misaligned/out-of-range error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] AddrLimit = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WaitInit  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cap_q, cap_d;
    logic        cap_err_q, cap_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [IdxW-1:0] idx;
    logic            accept;
    logic            addr_err;
    logic [31:0]     load_word;

    assign idx       = bus.req_addr[IdxW+1:2];
    assign accept    = bus.req_valid && (state_q == StIdle);
    assign addr_err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= AddrLimit);
    assign load_word = (addr_err || bus.req_we) ? 32'd0 : mem[idx];

    // Storage is deliberately not reset; stores commit at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_be[b]) begin
                    mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            cap_q     <= 32'd0;
            cap_err_q <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            cap_err_q <= cap_err_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Response registers only change on entry to and exit from RESP.
    always_comb begin
        cap_d     = cap_q;
        cap_err_d = cap_err_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        if (accept) begin
            cap_d     = load_word;
            cap_err_d = addr_err;
        end
        if ((state_q != StResp) && (state_d == StResp)) begin
            rdata_d = (state_q == StIdle) ? load_word : cap_q;
            err_d   = (state_q == StIdle) ? addr_err  : cap_err_q;
        end else if ((state_q == StResp) && (state_d == StIdle)) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

endmodule
